// File: rtl/membus_pkg.sv
`default_nettype none
// ============================================================================
// Package  : membus_pkg
// Brief    : Shared types, constants and slice helpers for the membus core memory.
// Revision : 1.0
// ============================================================================
package membus_pkg;

    localparam int WORD_W    = 36;
    localparam int FMC_LIMIT = 16;
    localparam int MAX_PORTS = 4;
    localparam int IDX_W     = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACK   = 3'd1,
        RD    = 3'd2,
        RD2   = 3'd3,
        WWAIT = 3'd4,
        REST  = 3'd5
    } state_t;

    // Select code nibble for port p out of the packed per-port code word.
    function automatic logic [3:0] sel_nib(input logic [4*MAX_PORTS-1:0] codes,
                                           input int unsigned p);
        logic [4*MAX_PORTS-1:0] shifted;
        shifted = codes >> (p * 4);
        return shifted[3:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/membus_prio_arb.sv
`default_nettype none
// ============================================================================
// Module   : membus_prio_arb
// Brief    : Fixed-priority arbiter, lowest index wins; one-hot grant plus index.
// Revision : 1.0
// ============================================================================
import membus_pkg::*;

module membus_prio_arb #(
    parameter int NPORTS = 4
) (
    input  logic [NPORTS-1:0] req,
    output logic [NPORTS-1:0] grant,
    output logic [IDX_W-1:0]  idx,
    output logic              any
);

    // Scanning downward lets the lowest requesting index overwrite the rest.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
            end
        end
    end

    assign any = |req;

endmodule
`default_nettype wire

// File: rtl/membus_core_mem.sv
`default_nettype none
// ============================================================================
// Module   : membus_core_mem
// Brief    : Multi-port 36-bit core memory with priority arbitration, FMC
//            exclusion and read / write / read-modify-write cycles.
// Revision : 1.0
// ============================================================================
import membus_pkg::*;

module membus_core_mem #(
    parameter int          NPORTS  = 4,
    parameter int          ADDR_W  = 15,
    parameter logic [15:0] MEMSEL  = 16'h0000,
    parameter int          ACC_CYC = 4,
    parameter int          WR_CYC  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     power,
    input  logic [NPORTS-1:0]        rq_cyc,
    input  logic [NPORTS-1:0]        rd_rq,
    input  logic [NPORTS-1:0]        wr_rq,
    input  logic [NPORTS-1:0]        wr_rs,
    input  logic [NPORTS-1:0]        fmc_select,
    input  logic [NPORTS*ADDR_W-1:0] ma,
    input  logic [NPORTS*4-1:0]      sel,
    input  logic [NPORTS*WORD_W-1:0] mb_in,
    output logic [NPORTS-1:0]        addr_ack,
    output logic [NPORTS-1:0]        rd_rs,
    output logic [NPORTS*WORD_W-1:0] mb_out,
    output logic                     busy
);

    localparam logic [3:0] c_acc_load = 4'(ACC_CYC - 1);
    localparam logic [3:0] c_wr_load  = 4'(WR_CYC - 1);

    state_t                r_state, w_nxt;
    logic [3:0]            r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]      r_gidx, w_idx;
    logic [ADDR_W-1:0]     r_ma, w_cap_ma;
    logic                  r_rd, r_wr;
    logic [WORD_W-1:0]     r_rdata, w_wdata;
    logic [WORD_W-1:0]     r_mem [2**ADDR_W];

    logic [NPORTS-1:0]     w_elig, w_grant, w_gmask;
    logic                  w_any, w_latch, w_rd_en, w_we, w_g_rq, w_g_wrs;
    logic                  w_ack_phase, w_rd_phase;
    logic [ADDR_W-1:0]     w_ma_arr [NPORTS];
    logic [WORD_W-1:0]     w_wd_arr [NPORTS];

    assign w_gmask     = NPORTS'(1) << r_gidx;
    assign w_g_rq      = |(rq_cyc & w_gmask);
    assign w_g_wrs     = |(wr_rs & w_gmask);
    assign w_ack_phase = power && (r_state == ACK);
    assign w_rd_phase  = power && (r_state == RD2);
    assign busy        = power && (r_state != IDLE);

    generate
        for (genvar p = 0; p < NPORTS; p++) begin : g_port
            assign w_ma_arr[p] = ma[p*ADDR_W +: ADDR_W];
            assign w_wd_arr[p] = mb_in[p*WORD_W +: WORD_W];
            assign w_elig[p]   = power && rq_cyc[p]
                               && (sel[p*4 +: 4] == sel_nib(MEMSEL, p))
                               && !(fmc_select[p] && (w_ma_arr[p] < ADDR_W'(FMC_LIMIT)));
            assign addr_ack[p] = w_ack_phase && w_gmask[p];
            assign rd_rs[p]    = w_rd_phase && w_gmask[p];
            // Non-granted ports stay zero so the response OR-tree sees only one driver.
            assign mb_out[p*WORD_W +: WORD_W] = (w_rd_phase && w_gmask[p]) ? r_rdata : '0;
        end
    endgenerate

    membus_prio_arb #(
        .NPORTS (NPORTS)
    ) u_arb (
        .req   (w_elig),
        .grant (w_grant),
        .idx   (w_idx),
        .any   (w_any)
    );

    always_comb begin
        w_cap_ma = '0;
        w_wdata  = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (w_grant[p]) w_cap_ma = w_cap_ma | w_ma_arr[p];
            if (w_gmask[p]) w_wdata  = w_wdata | w_wd_arr[p];
        end
    end

    always_comb begin
        w_nxt     = r_state;
        w_cnt_nxt = r_cnt;
        w_latch   = 1'b0;
        w_rd_en   = 1'b0;
        w_we      = 1'b0;
        if (!power) begin
            w_nxt     = IDLE;
            w_cnt_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        w_latch = 1'b1;
                        w_nxt   = ACK;
                    end
                end
                ACK: begin
                    if (!w_g_rq) begin
                        w_nxt     = REST;
                        w_cnt_nxt = c_wr_load;
                    end else if (r_rd) begin
                        w_rd_en = 1'b1;
                        if (ACC_CYC == 1) begin
                            w_nxt = RD2;
                        end else begin
                            w_nxt     = RD;
                            w_cnt_nxt = c_acc_load;
                        end
                    end else begin
                        w_nxt = WWAIT;
                    end
                end
                RD: begin
                    if (!w_g_rq) begin
                        w_nxt     = REST;
                        w_cnt_nxt = c_wr_load;
                    end else begin
                        w_rd_en = 1'b1;
                        if (r_cnt <= 4'd1) w_nxt = RD2;
                        else               w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
                RD2: begin
                    if (r_wr && w_g_rq) begin
                        w_nxt = WWAIT;
                    end else begin
                        w_nxt     = REST;
                        w_cnt_nxt = c_wr_load;
                    end
                end
                WWAIT: begin
                    // A dropped request wins over a simultaneous restart: no write.
                    if (!w_g_rq || w_g_wrs) begin
                        w_we      = w_g_rq;
                        w_nxt     = REST;
                        w_cnt_nxt = c_wr_load;
                    end
                end
                REST: begin
                    if (r_cnt == 4'd0) w_nxt = IDLE;
                    else               w_cnt_nxt = r_cnt - 4'd1;
                end
                default: begin
                    w_nxt     = IDLE;
                    w_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_gidx  <= '0;
            r_ma    <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch) begin
                r_gidx <= w_idx;
                r_ma   <= w_cap_ma;
                r_rd   <= |(rd_rq & w_grant);
                r_wr   <= |(wr_rq & w_grant);
            end
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (w_we)    r_mem[r_ma] <= w_wdata;
        if (w_rd_en) r_rdata     <= r_mem[r_ma];
    end

endmodule
`default_nettype wire

// File: tb/tb_membus_core_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_membus_core_mem
// Brief    : Scoreboard bench for membus_core_mem (reads, RMW, contention, aborts).
// Revision : 1.0
// ============================================================================
module tb_membus_core_mem;

    localparam int NP  = 4;
    localparam int AW  = 15;
    localparam int WW  = 36;
    localparam int ACC = 4;
    localparam int WRC = 2;

    typedef struct {
        int          port;
        logic [35:0] data;
    } exp_t;

    logic            clk, reset, power;
    logic [NP-1:0]   rq_cyc, rd_rq, wr_rq, wr_rs, fmc_select;
    logic [NP*AW-1:0] ma;
    logic [NP*4-1:0]  sel;
    logic [NP*WW-1:0] mb_in;
    logic [NP-1:0]   addr_ack, rd_rs;
    logic [NP*WW-1:0] mb_out;
    logic            busy;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    membus_core_mem #(
        .NPORTS (NP), .ADDR_W (AW), .MEMSEL (16'h0000), .ACC_CYC (ACC), .WR_CYC (WRC)
    ) dut (
        .clk (clk), .reset (reset), .power (power), .rq_cyc (rq_cyc), .rd_rq (rd_rq),
        .wr_rq (wr_rq), .wr_rs (wr_rs), .fmc_select (fmc_select), .ma (ma), .sel (sel),
        .mb_in (mb_in), .addr_ack (addr_ack), .rd_rs (rd_rs), .mb_out (mb_out), .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_req(input int p, input logic [AW-1:0] a, input logic rd, input logic wr);
        ma[p*AW +: AW] = a;
        rd_rq[p]  = rd;
        wr_rq[p]  = wr;
        rq_cyc[p] = 1'b1;
    endtask

    task automatic wait_ack(input int p, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (addr_ack[p]) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_idle(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic do_write(input int p, input logic [AW-1:0] a, input logic [35:0] d);
        logic ok;
        drive_req(p, a, 1'b0, 1'b1);
        wait_ack(p, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL wr_ack port %0d: no addr_ack", p); end
        @(negedge clk);
        wr_rs[p] = 1'b1;
        mb_in[p*WW +: WW] = d;
        @(negedge clk);
        wr_rs[p] = 1'b0; rq_cyc[p] = 1'b0; wr_rq[p] = 1'b0;
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL wr_idle port %0d: busy stuck", p); end
    endtask

    task automatic do_read(input int p, input logic [AW-1:0] a, input logic [35:0] exp_d,
                           input logic rmw, input logic [35:0] wdata);
        logic ok;
        int n;
        exp_t e;
        logic [NP*WW-1:0] others;
        sb_q.push_back('{p, exp_d});
        drive_req(p, a, 1'b1, rmw);
        wait_ack(p, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rd_ack port %0d: no addr_ack", p); end
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (rd_rs[p]) break;
        end
        checks++;
        if (n != ACC) begin errors++; $display("FAIL rd_latency port %0d: got %0d want %0d", p, n, ACC); end
        e = sb_q.pop_front();
        checks++;
        if (!rd_rs[p] || e.port != p || mb_out[p*WW +: WW] !== e.data) begin
            errors++;
            $display("FAIL rd_data port %0d: got %o want %o", p, mb_out[p*WW +: WW], e.data);
        end
        others = mb_out;
        others[p*WW +: WW] = '0;
        checks++;
        if (others !== '0) begin errors++; $display("FAIL rd_orbus port %0d: others %h want 0", p, others); end
        if (rmw) begin
            @(negedge clk);
            wr_rs[p] = 1'b1;
            mb_in[p*WW +: WW] = wdata;
            @(negedge clk);
            wr_rs[p] = 1'b0;
        end
        rq_cyc[p] = 1'b0; rd_rq[p] = 1'b0; wr_rq[p] = 1'b0;
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rd_idle port %0d: busy stuck", p); end
    endtask

    task automatic test_reset();
        reset = 1'b0; power = 1'b0;
        rq_cyc = '0; rd_rq = '0; wr_rq = '0; wr_rs = '0; fmc_select = '0;
        ma = '0; sel = '0; mb_in = '0;
        @(negedge clk);
        power = 1'b1;
        rq_cyc[0] = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++;
        if (addr_ack !== '0 || rd_rs !== '0 || mb_out !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: ack %b rs %b busy %b want 0", addr_ack, rd_rs, busy);
        end
        rq_cyc = '0;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read();
        do_write(0, 15'o20, 36'o102030405060);
        do_read(0, 15'o20, 36'o102030405060, 1'b0, '0);
    endtask

    task automatic test_rmw();
        do_write(1, 15'd5, 36'd7);
        do_read(1, 15'd5, 36'd7, 1'b1, 36'o777777777777);
        do_read(1, 15'd5, 36'o777777777777, 1'b0, '0);
    endtask

    task automatic test_wr_rs_ignore();
        logic ok;
        drive_req(0, 15'o30, 1'b0, 1'b1);
        wait_ack(0, ok);
        @(negedge clk);
        wr_rs[2] = 1'b1; mb_in[2*WW +: WW] = 36'o123;
        @(negedge clk);
        wr_rs[2] = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL foreign_wr_rs: busy %b want 1", busy); end
        wr_rs[0] = 1'b1; mb_in[0 +: WW] = 36'o4444;
        @(negedge clk);
        wr_rs[0] = 1'b0; rq_cyc[0] = 1'b0; wr_rq[0] = 1'b0;
        wait_idle(ok);
        do_read(0, 15'o30, 36'o4444, 1'b0, '0);
    endtask

    task automatic test_contention();
        int   t0 = -1, t2 = -1, served = 0;
        logic overlap = 1'b0;
        exp_t e;
        sb_q.push_back('{0, 36'o102030405060});
        sb_q.push_back('{2, 36'o777777777777});
        drive_req(0, 15'o20, 1'b1, 1'b0);
        drive_req(2, 15'd5, 1'b1, 1'b0);
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if ($countones(addr_ack) > 1) overlap = 1'b1;
            if (addr_ack[0] && t0 < 0) t0 = cyc;
            if (addr_ack[2] && t2 < 0) t2 = cyc;
            for (int p = 0; p < NP; p++) begin
                if (rd_rs[p] && sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    checks++;
                    if (e.port != p || mb_out[p*WW +: WW] !== e.data) begin
                        errors++;
                        $display("FAIL contention_data: port %0d data %o want port %0d data %o",
                                 p, mb_out[p*WW +: WW], e.port, e.data);
                    end
                    rq_cyc[p] = 1'b0; rd_rq[p] = 1'b0;
                    served++;
                end
            end
            if (served == 2 && !busy) break;
        end
        checks++;
        if (served != 2) begin errors++; $display("FAIL contention_served: got %0d want 2", served); end
        checks++;
        if (t0 < 0 || t2 - t0 != ACC + WRC + 2) begin
            errors++;
            $display("FAIL contention_order: ack0 at %0d ack2 at %0d want spacing %0d", t0, t2, ACC + WRC + 2);
        end
        checks++;
        if (overlap) begin errors++; $display("FAIL contention_overlap: got 1 want 0"); end
        sb_q.delete();
    endtask

    task automatic test_fmc();
        logic seen = 1'b0;
        fmc_select[0] = 1'b1;
        drive_req(0, 15'd3, 1'b1, 1'b0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (addr_ack[0] || busy) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL fmc_block: activity %b want 0", seen); end
        do_read(0, 15'd16, 36'o102030405060, 1'b0, '0);
        fmc_select[0] = 1'b0;
    endtask

    task automatic test_power_abort();
        logic ok;
        drive_req(0, 15'o20, 1'b0, 1'b1);
        wait_ack(0, ok);
        @(negedge clk);
        power = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || addr_ack !== '0 || mb_out !== '0) begin
            errors++;
            $display("FAIL power_outputs: busy %b ack %b want 0", busy, addr_ack);
        end
        @(negedge clk);
        wr_rs[0] = 1'b1; mb_in[0 +: WW] = 36'o1;
        @(negedge clk);
        wr_rs[0] = 1'b0; rq_cyc[0] = 1'b0; wr_rq[0] = 1'b0;
        @(negedge clk);
        power = 1'b1;
        do_read(0, 15'o20, 36'o102030405060, 1'b0, '0);
    endtask

    task automatic test_rq_drop();
        logic ok;
        drive_req(1, 15'd5, 1'b0, 1'b1);
        wait_ack(1, ok);
        @(negedge clk);
        rq_cyc[1] = 1'b0; wr_rs[1] = 1'b1; mb_in[1*WW +: WW] = 36'o55;
        @(negedge clk);
        wr_rs[1] = 1'b0; wr_rq[1] = 1'b0;
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rq_drop_idle: busy stuck"); end
        do_read(1, 15'd5, 36'o777777777777, 1'b0, '0);
    endtask

    task automatic test_reset_in_rd();
        logic ok;
        drive_req(0, 15'd5, 1'b1, 1'b0);
        wait_ack(0, ok);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || addr_ack !== '0 || rd_rs !== '0 || mb_out !== '0) begin
            errors++;
            $display("FAIL reset_in_rd: busy %b ack %b rs %b want 0", busy, addr_ack, rd_rs);
        end
        rq_cyc[0] = 1'b0; rd_rq[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        do_read(0, 15'd5, 36'o777777777777, 1'b0, '0);
    endtask

    task automatic test_sel_mismatch();
        logic seen = 1'b0;
        sel[3*4 +: 4] = 4'b0011;
        drive_req(3, 15'o20, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (addr_ack[3] || busy) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL sel_mismatch: activity %b want 0", seen); end
        rq_cyc[3] = 1'b0; rd_rq[3] = 1'b0; sel[3*4 +: 4] = 4'b0000;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_read();
        test_rmw();
        test_wr_rs_ignore();
        test_contention();
        test_fmc();
        test_power_abort();
        test_rq_drop();
        test_reset_in_rd();
        test_sel_mismatch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
